kmer_window_extractor: RTL and testbench
========================================

Name: kmer_window_extractor

Overview:
- Upstream feeder of the canonical-k-mer stage. Takes a read as a stream of 2-bit nucleotides and emits every sliding-window k-mer of the programmed length, one per accepted base once the window is full.
- Output format and the global `ready` stall match what the canonical stage consumes: k-mer in the low 2·k bits, zero-extended.
- Windows containing an ambiguous base (N) are suppressed. Each emitted k-mer carries its start position within the read.

Parameters:
- MAX_KMER_BIT_WIDTH, 6, width of kmerLength. Legal k = 1..2^MAX_KMER_BIT_WIDTH-1.
- MAX_KMER_WIDTH, 2^MAX_KMER_BIT_WIDTH, maximum window in nucleotides. Sets the output bus width.
- POS_WIDTH, 16, width of the k-mer start-position counter.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset.
- ready  in  1  global downstream enable. All state advances only when high.
- baseValid  in  1  input base present.
- base  in  2  nucleotide: A=00, C=01, G=10, T=11.
- baseIsN  in  1  base is ambiguous. `base` is ignored.
- baseSor  in  1  first base of a read.
- baseEor  in  1  last base of a read.
- baseReady  out  1  base accepted this cycle when baseValid&baseReady.
- kmerLength  in  MAX_KMER_BIT_WIDTH  k. Sampled on the SOR beat.
- kmerValid  out  1  output k-mer valid.
- kmer  out  2*MAX_KMER_WIDTH  window. Oldest base most significant. Bits at or above 2k are zero.
- kmerLengthOut  out  MAX_KMER_BIT_WIDTH  latched k for this read.
- kmerPos  out  POS_WIDTH  0-based read index of the k-mer's first base.
- readDone  out  1  one-beat flag: EOR base was processed in this output beat.
- protocolErr  out  1  sticky; cleared only by reset.

Behaviour:
- Reset is rstb, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, window 0, fill count 0, position 0, state IDLE.
- Handshake:
  - baseReady = ready, combinational.
  - Accept = baseValid & ready.
  - With ready=0, every register holds and outputs stay stable.
- Latency: 1 cycle. A base accepted at edge n drives its outputs after edge n.
- With ready=1 and no accept: kmerValid <= 0 and readDone <= 0.
- State IDLE:
  - An accepted base without baseSor is dropped, protocolErr <= 1, no output.
  - Accepted base with baseSor: latch len = kmerLength, clear window, pos = 0, process the base as below, go ACTIVE.
- Per processed base:
  - Window: window <= ((window << 2) | base) & mask, where mask has the low 2·len bits set.
  - Fill count: 0 if baseIsN, else min(count+1, len).
  - Base index: increments by 1, wrapping modulo 2^POS_WIDTH. Reads longer than that are unsupported.
- Emit rule: kmerValid <= 1 iff the new count == len and the base is not N.
  - kmer = new window.
  - kmerPos = index of this base − len + 1.
  - kmerLengthOut = len.
- ACTIVE, accepted base with baseSor: the previous read is abandoned without readDone, protocolErr <= 1, and the base is handled as a fresh SOR.
- baseEor: the base is processed normally, readDone <= 1 in the same output beat, state -> IDLE.
- baseSor and baseEor on the same beat: a single-base read. It emits only if len == 1.
- len == 0: no k-mers emitted. readDone is still produced.
- Reset mid-read: everything returns to reset values. The next read must start with SOR.

Optional Feature:
- Macro KMER_WINDOW_STATS_EN.
- Defined: adds input statsClear (1) and outputs kmerCount (32) and nBaseCount (32).
  - kmerCount increments on each emitted k-mer.
  - nBaseCount increments on each accepted baseIsN.
  - Both saturate at all-ones and are cleared synchronously by statsClear. Clear wins over a simultaneous increment.
  - Asynchronous reset clears both to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- len=3, read A(SOR) C G T(EOR), ready=1 -> kmer=6'h06 pos 0, then kmer=6'h1B pos 1 with readDone=1. Upper bits are 0.
- len=2, read A C N G T -> emits AC=4'h1 pos 0 and GT=4'hB pos 3 only. Nothing at the N or at G.
- len=3 ACGT with ready forced low for 3 cycles after the second base -> baseReady=0, outputs frozen, no bases lost. The same two k-mers come out after the stall.
- len=1, single beat T with SOR and EOR -> kmer=3, pos 0, readDone=1, state IDLE.
- Base without SOR in IDLE -> no kmerValid, protocolErr=1, which persists until rstb is asserted.
- rstb asserted after 2 bases of a len=3 read, then new read GGG -> first output kmer=6'h2A pos 0. No stale data.

Source files
------------

// File: rtl/kmer_window_extractor.sv
// kmer_window_extractor
// Slides a k-nucleotide window over a read streamed as 2-bit bases and emits
// every full, N-free window (oldest base in the MSBs, zero-extended above 2k)
// together with its 0-based start position in the read.
//
// Ports:
//   clk, rstb          clock, asynchronous active-low reset
//   ready              global enable; nothing advances while low
//   baseValid/base     input nucleotide (A=00 C=01 G=10 T=11)
//   baseIsN            ambiguous base, base value ignored
//   baseSor/baseEor    first / last base of a read
//   baseReady          combinational accept indication (= ready)
//   kmerLength         k, sampled on the SOR beat
//   kmerValid/kmer     emitted window
//   kmerLengthOut      k latched for the read
//   kmerPos            start position of the emitted window
//   readDone           EOR base processed in this output beat
//   protocolErr        sticky protocol violation flag
//
// Optional statistics: define KMER_WINDOW_STATS_EN to add statsClear,
// kmerCount and nBaseCount.
module kmer_window_extractor #(
  parameter int unsigned MAX_KMER_BIT_WIDTH = 6,
  parameter int unsigned MAX_KMER_WIDTH     = 2**MAX_KMER_BIT_WIDTH,
  parameter int unsigned POS_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ready,
  input  logic                          baseValid,
  input  logic [1:0]                    base,
  input  logic                          baseIsN,
  input  logic                          baseSor,
  input  logic                          baseEor,
  output logic                          baseReady,
  input  logic [MAX_KMER_BIT_WIDTH-1:0] kmerLength,
  output logic                          kmerValid,
  output logic [2*MAX_KMER_WIDTH-1:0]   kmer,
  output logic [MAX_KMER_BIT_WIDTH-1:0] kmerLengthOut,
  output logic [POS_WIDTH-1:0]          kmerPos,
  output logic                          readDone,
  output logic                          protocolErr
`ifdef KMER_WINDOW_STATS_EN
  ,
  input  logic                          statsClear,
  output logic [31:0]                   kmerCount,
  output logic [31:0]                   nBaseCount
`endif
);

  localparam int unsigned KW = 2 * MAX_KMER_WIDTH;
  localparam int unsigned LW = MAX_KMER_BIT_WIDTH;
  localparam int unsigned SW = MAX_KMER_BIT_WIDTH + 2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_nxt;
  logic [KW-1:0]        win_q, win_nxt;
  logic [LW-1:0]        cnt_q, cnt_nxt;
  logic [LW-1:0]        len_q, len_nxt;
  logic [POS_WIDTH-1:0] idx_q, idx_nxt;

  logic                 kv_nxt, done_nxt, err_nxt;
  logic [KW-1:0]        kmer_nxt;
  logic [LW-1:0]        klo_nxt;
  logic [POS_WIDTH-1:0] pos_nxt;

  logic                 accept, take, emit;
  logic [LW-1:0]        cur_len, cur_cnt, cnt_new;
  logic [KW-1:0]        cur_win, mask, shifted;
  logic [POS_WIDTH-1:0] cur_idx;
  logic [LW:0]          cnt_inc;
  logic [SW-1:0]        shift_amt;

  assign baseReady = ready;
  assign accept    = baseValid & ready;
  // A non-SOR base in IDLE has no read to belong to and is dropped.
  assign take      = accept & ((state_q == ACTIVE) | baseSor);

  // SOR restarts from an empty window regardless of current state.
  assign cur_len   = baseSor ? kmerLength : len_q;
  assign cur_win   = baseSor ? KW'(0) : win_q;
  assign cur_cnt   = baseSor ? LW'(0) : cnt_q;
  assign cur_idx   = baseSor ? POS_WIDTH'(0) : idx_q;

  assign shift_amt = SW'({cur_len, 1'b0});
  assign mask      = ~({KW{1'b1}} << shift_amt);
  assign shifted   = ((cur_win << 2) | KW'(baseIsN ? 2'b00 : base)) & mask;
  assign cnt_inc   = (LW+1)'(cur_cnt) + (LW+1)'(1);
  assign cnt_new   = baseIsN ? LW'(0)
                   : (cnt_inc > (LW+1)'(cur_len)) ? cur_len : cnt_inc[LW-1:0];
  assign emit      = !baseIsN && (cur_len != LW'(0)) && (cnt_new == cur_len);

  // Next-state and output computation.
  always_comb begin
    state_nxt = state_q;
    win_nxt   = win_q;
    cnt_nxt   = cnt_q;
    len_nxt   = len_q;
    idx_nxt   = idx_q;
    kv_nxt    = kmerValid;
    done_nxt  = readDone;
    err_nxt   = protocolErr;
    kmer_nxt  = kmer;
    klo_nxt   = kmerLengthOut;
    pos_nxt   = kmerPos;

    if (ready) begin
      kv_nxt   = 1'b0;
      done_nxt = 1'b0;
    end

    if (accept && !take) begin
      err_nxt = 1'b1;
    end else if (take) begin
      if (baseSor && (state_q == ACTIVE)) err_nxt = 1'b1;
      len_nxt = cur_len;
      win_nxt = shifted;
      cnt_nxt = cnt_new;
      idx_nxt = cur_idx + POS_WIDTH'(1);
      if (emit) begin
        kv_nxt   = 1'b1;
        kmer_nxt = shifted;
        klo_nxt  = cur_len;
        pos_nxt  = cur_idx - POS_WIDTH'(cur_len) + POS_WIDTH'(1);
      end
      if (baseEor) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = ACTIVE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      win_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      kmerValid     <= 1'b0;
      kmer          <= '0;
      kmerLengthOut <= '0;
      kmerPos       <= '0;
      readDone      <= 1'b0;
      protocolErr   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      win_q         <= win_nxt;
      cnt_q         <= cnt_nxt;
      len_q         <= len_nxt;
      idx_q         <= idx_nxt;
      kmerValid     <= kv_nxt;
      kmer          <= kmer_nxt;
      kmerLengthOut <= klo_nxt;
      kmerPos       <= pos_nxt;
      readDone      <= done_nxt;
      protocolErr   <= err_nxt;
    end
  end

`ifdef KMER_WINDOW_STATS_EN
  logic [31:0] kcnt_nxt, ncnt_nxt;

  // Saturating statistics; clear has priority over increment.
  always_comb begin
    kcnt_nxt = kmerCount;
    ncnt_nxt = nBaseCount;
    if (ready) begin
      if (statsClear) begin
        kcnt_nxt = '0;
        ncnt_nxt = '0;
      end else begin
        if (take && emit && (kmerCount != '1))       kcnt_nxt = kmerCount + 32'd1;
        if (accept && baseIsN && (nBaseCount != '1)) ncnt_nxt = nBaseCount + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      kmerCount  <= '0;
      nBaseCount <= '0;
    end else begin
      kmerCount  <= kcnt_nxt;
      nBaseCount <= ncnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_kmer_window_extractor.sv
// Self-checking bench for kmer_window_extractor (default build).
module tb_kmer_window_extractor;

  logic         clk = 1'b0;
  logic         rstb;
  logic         ready;
  logic         baseValid;
  logic [1:0]   base;
  logic         baseIsN;
  logic         baseSor;
  logic         baseEor;
  logic         baseReady;
  logic [5:0]   kmerLength;
  logic         kmerValid;
  logic [127:0] kmer;
  logic [5:0]   kmerLengthOut;
  logic [15:0]  kmerPos;
  logic         readDone;
  logic         protocolErr;

  typedef struct packed {
    logic         v;
    logic [127:0] k;
    logic [15:0]  p;
    logic [5:0]   l;
    logic         d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic rdy_edge = 1'b0;

  logic [1:0] rb [0:127];
  logic       rn [0:127];

  always #5 clk = ~clk;

  kmer_window_extractor dut (
    .clk(clk), .rstb(rstb), .ready(ready), .baseValid(baseValid), .base(base),
    .baseIsN(baseIsN), .baseSor(baseSor), .baseEor(baseEor), .baseReady(baseReady),
    .kmerLength(kmerLength), .kmerValid(kmerValid), .kmer(kmer),
    .kmerLengthOut(kmerLengthOut), .kmerPos(kmerPos), .readDone(readDone),
    .protocolErr(protocolErr)
  );

  function automatic exp_t mk(logic v, logic [127:0] k, logic [15:0] p, logic [5:0] l, logic d);
    exp_t e;
    e.v = v; e.k = k; e.p = p; e.l = l; e.d = d;
    return e;
  endfunction

  // Scoreboard: compare each output beat produced by an enabled edge.
  always @(posedge clk) rdy_edge = ready & rstb;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rdy_edge && (kmerValid || readDone)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: kmerValid=%0b readDone=%0b kmer=%h pos=%0d, required no output",
                 kmerValid, readDone, kmer, kmerPos);
      end else begin
        e = q.pop_front();
        if ({kmerValid, readDone} !== {e.v, e.d}) begin
          errors++;
          $display("FAIL beat_flags: kmerValid/readDone=%b%b required %b%b", kmerValid, readDone, e.v, e.d);
        end
        if (e.v) begin
          checks++;
          if (kmer !== e.k || kmerPos !== e.p || kmerLengthOut !== e.l) begin
            errors++;
            $display("FAIL kmer_fields: kmer=%h pos=%0d len=%0d required kmer=%h pos=%0d len=%0d",
                     kmer, kmerPos, kmerLengthOut, e.k, e.p, e.l);
          end
        end
      end
    end
  end

  task automatic drive_base(input logic [1:0] b, input logic n, input logic sor,
                            input logic eor, input logic [5:0] len);
    @(negedge clk);
    baseValid = 1'b1; base = b; baseIsN = n; baseSor = sor; baseEor = eor; kmerLength = len;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    baseValid = 1'b0; baseSor = 1'b0; baseEor = 1'b0; baseIsN = 1'b0; base = 2'b00;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({kmerValid, kmer, kmerLengthOut, kmerPos, readDone, protocolErr} !== '0) begin
      errors++;
      $display("FAIL %s: kv=%0b kmer=%h klen=%0d pos=%0d done=%0b err=%0b required all zero",
               name, kmerValid, kmer, kmerLengthOut, kmerPos, readDone, protocolErr);
    end
  endtask

  // Reference: rebuild every window from the raw read history.
  task automatic run_model(input int len, input int nb, input string name);
    for (int i = 0; i < nb; i++) begin
      logic         ok;
      logic [127:0] k;
      ok = (len > 0) && (i + 1 >= len);
      k  = '0;
      if (ok) begin
        for (int j = i - len + 1; j <= i; j++) begin
          if (rn[j]) ok = 1'b0;
          k = (k << 2) | 128'(rb[j]);
        end
      end
      if (ok || i == nb - 1)
        q.push_back(mk(ok, ok ? k : 128'd0, 16'(i - len + 1), 6'(len), i == nb - 1));
    end
    for (int i = 0; i < nb; i++)
      drive_base(rb[i], rn[i], i == 0, i == nb - 1, 6'(len));
    idle();
    wait_drain(name);
  endtask

  task automatic test_reset();
    rstb = 1'b0; ready = 1'b1; kmerLength = 6'd0;
    baseValid = 1'b0; base = 2'b00; baseIsN = 1'b0; baseSor = 1'b0; baseEor = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    checks++;
    if (baseReady !== 1'b1) begin
      errors++;
      $display("FAIL base_ready: got %0b required 1", baseReady);
    end
    rstb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    q.push_back(mk(1'b1, 128'h06, 16'd0, 6'd3, 1'b0));
    q.push_back(mk(1'b1, 128'h1B, 16'd1, 6'd3, 1'b1));
    drive_base(2'd0, 0, 1, 0, 6'd3);
    drive_base(2'd1, 0, 0, 0, 6'd0);
    drive_base(2'd2, 0, 0, 0, 6'd0);
    drive_base(2'd3, 0, 0, 1, 6'd0);
    idle();
    wait_drain("basic");
  endtask

  task automatic test_n_base();
    q.push_back(mk(1'b1, 128'h1, 16'd0, 6'd2, 1'b0));
    q.push_back(mk(1'b1, 128'hB, 16'd3, 6'd2, 1'b1));
    drive_base(2'd0, 0, 1, 0, 6'd2);
    drive_base(2'd1, 0, 0, 0, 6'd2);
    drive_base(2'd1, 1, 0, 0, 6'd2);
    drive_base(2'd2, 0, 0, 0, 6'd2);
    drive_base(2'd3, 0, 0, 1, 6'd2);
    idle();
    wait_drain("n_base");
  endtask

  task automatic test_stall();
    logic [152:0] snap;
    q.push_back(mk(1'b1, 128'h06, 16'd0, 6'd3, 1'b0));
    q.push_back(mk(1'b1, 128'h1B, 16'd1, 6'd3, 1'b1));
    drive_base(2'd0, 0, 1, 0, 6'd3);
    drive_base(2'd1, 0, 0, 0, 6'd3);
    @(negedge clk);
    ready = 1'b0; baseValid = 1'b1; base = 2'd2; baseSor = 1'b0; baseEor = 1'b0; baseIsN = 1'b0;
    #1;
    snap = {kmerValid, kmer, kmerLengthOut, kmerPos, readDone, protocolErr};
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (baseReady !== 1'b0 || {kmerValid, kmer, kmerLengthOut, kmerPos, readDone, protocolErr} !== snap) begin
        errors++;
        $display("FAIL stall_frozen: baseReady=%0b kv=%0b kmer=%h pos=%0d required baseReady=0 and held outputs",
                 baseReady, kmerValid, kmer, kmerPos);
      end
    end
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    drive_base(2'd3, 0, 0, 1, 6'd3);
    idle();
    wait_drain("stall");
  endtask

  task automatic test_single_base();
    q.push_back(mk(1'b1, 128'h3, 16'd0, 6'd1, 1'b1));
    drive_base(2'd3, 0, 1, 1, 6'd1);
    idle();
    wait_drain("single_base");
  endtask

  task automatic test_random_reads();
    for (int r = 0; r < 4; r++) begin
      int len, nb;
      len = $urandom_range(1, 6);
      nb  = $urandom_range(len, 12);
      for (int i = 0; i < nb; i++) begin
        rb[i] = 2'($urandom_range(0, 3));
        rn[i] = ($urandom_range(0, 7) == 0);
      end
      run_model(len, nb, "random");
    end
    for (int i = 0; i < 3; i++) begin
      rb[i] = 2'($urandom_range(0, 3));
      rn[i] = 1'b0;
    end
    run_model(0, 3, "len_zero");
    for (int i = 0; i < 66; i++) begin
      rb[i] = 2'($urandom_range(0, 3));
      rn[i] = 1'b0;
    end
    run_model(63, 66, "max_len");
  endtask

  task automatic test_protocol();
    checks++;
    if (protocolErr !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: protocolErr=%0b required 0", protocolErr);
    end
    drive_base(2'd3, 0, 0, 0, 6'd3);
    idle();
    @(negedge clk);
    checks++;
    if (protocolErr !== 1'b1 || kmerValid !== 1'b0) begin
      errors++;
      $display("FAIL no_sor: protocolErr=%0b kmerValid=%0b required 1 and 0", protocolErr, kmerValid);
    end
    // SOR while a read is open abandons it and starts afresh.
    q.push_back(mk(1'b1, 128'h6, 16'd0, 6'd2, 1'b1));
    drive_base(2'd0, 0, 1, 0, 6'd2);
    drive_base(2'd1, 0, 1, 0, 6'd2);
    drive_base(2'd2, 0, 0, 1, 6'd2);
    idle();
    wait_drain("restart_sor");
    checks++;
    if (protocolErr !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: protocolErr=%0b required 1", protocolErr);
    end
  endtask

  task automatic test_reset_mid_read();
    drive_base(2'd0, 0, 1, 0, 6'd3);
    drive_base(2'd1, 0, 0, 0, 6'd3);
    @(negedge clk);
    baseValid = 1'b0; baseSor = 1'b0;
    rstb = 1'b0;
    #1;
    check_reset_outputs("mid_read_reset");
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    q.push_back(mk(1'b1, 128'h2A, 16'd0, 6'd3, 1'b1));
    drive_base(2'd2, 0, 1, 0, 6'd3);
    drive_base(2'd2, 0, 0, 0, 6'd3);
    drive_base(2'd2, 0, 0, 1, 6'd3);
    idle();
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n_base();
    test_stall();
    test_single_base();
    test_random_reads();
    test_protocol();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
